hazard_forwarding_unit: RTL and testbench
=========================================

# hazard_forwarding_unit

Parametrised operand-forwarding and hazard-control unit for the 5-stage pipelined core: it selects EX-stage operand sources (EX/MEM, MEM/WB or register file), bypasses same-cycle write-back into decode and detects load-use hazards. On a hazard it sequences a configurable number of bubble cycles. It also handles taken-branch flushes and data-memory busy freezes, and counts load-use stall cycles for performance monitoring. It sits beside the ID/EX pipeline registers and drives the stall, flush and mux-select lines of every front-end stage.

## Interface
- ADDR_W, 5, register address width; register file has 2^ADDR_W entries.
- LOAD_STALL, 1, bubble cycles inserted per load-use hazard; legal range 1..4.
- CNT_W, 16, width of the stall-cycle counter.
- ZERO_REG, 1, when 1, address 0 is hardwired zero and never forwarded, bypassed or hazard-checked.
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid, id_use_rs1, id_use_rs2  in  1 each  decode slot valid and source-operand usage flags.
- id_rs1, id_rs2  in  ADDR_W each  decode-stage source registers.
- ex_rs1, ex_rs2  in  ADDR_W each  EX-stage source registers.
- ex_rd  in  ADDR_W  EX destination register.
- ex_regwrite, ex_memread  in  1 each  EX destination write enable and load flag.
- ex_branch_taken  in  1  branch resolved taken in EX.
- exmem_rd  in  ADDR_W  EX/MEM destination register.
- exmem_regwrite, exmem_memread  in  1 each  EX/MEM write enable and load flag.
- memwb_rd  in  ADDR_W  MEM/WB destination register.
- memwb_regwrite  in  1  MEM/WB write enable.
- mem_busy  in  1  data memory not ready; entire pipeline must hold.
- cnt_clr  in  1  synchronous clear of stall_cycles.
- forward_a, forward_b  out  2 each  EX operand select: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
- id_bypass_a, id_bypass_b  out  1 each  decode reads the write-back value instead of the register file.
- stall_if, stall_id  out  1 each  hold PC and IF/ID, respectively.
- flush_ifid, flush_idex  out  1 each  turn IF/ID or ID/EX contents into a bubble on the next edge.
- freeze  out  1  hold all pipeline registers.
- stall_cycles  out  CNT_W  saturating count of load-use stall cycles.

## Operation
- The rd address is "live" when the matching regwrite is 1 and, if ZERO_REG = 1, rd != 0.
- forward_a is 10 if exmem_rd is live, equals ex_rs1 and exmem_memread = 0. Otherwise it is 01 if memwb_rd is live and equals ex_rs1. Otherwise it is 00. forward_b is the same using ex_rs2. EX/MEM has priority over MEM/WB.
- id_bypass_a = memwb_rd live and memwb_rd == id_rs1 and id_use_rs1. id_bypass_b is the same using rs2.
- hit = id_valid & ex_memread & (ex_rd live) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- FSM states: RUN and LU_STALL. Down-counter cnt has width clog2(LOAD_STALL)+1.
  - RUN, with hit & !ex_branch_taken & !mem_busy: assert stall_if, stall_id and flush_idex. If LOAD_STALL > 1, go to LU_STALL with cnt = LOAD_STALL-1; otherwise stay in RUN.
  - LU_STALL: assert stall_if, stall_id and flush_idex. hit is ignored. cnt decrements each cycle. Return to RUN when cnt = 1 and there is no freeze.
- ex_branch_taken: assert flush_ifid and flush_idex. The branch wins over hit. In RUN, no stall is raised and the state stays RUN.
- mem_busy: freeze = 1. All stall and flush outputs are 0, and the FSM and cnt hold. A hit detected under freeze is re-evaluated in the first cycle after freeze.
- stall_cycles increments by 1 in each cycle where stall_if = 1 and freeze = 0. It saturates at 2^CNT_W-1. cnt_clr has priority over the increment.
- Reset:
  - While rst = 1: all control outputs and selects are 0.
  - On the next edge: state = RUN, cnt = 0, stall_cycles = 0.
  - A reset during LU_STALL abandons the remaining bubbles.

## Timing
- forward_*, id_bypass_*, stall_*, flush_* and freeze are combinational from the inputs and the current state, valid in the same cycle.
- A load-use hazard produces exactly LOAD_STALL consecutive non-frozen stall cycles, starting in the hit cycle. Freeze cycles extend the window without consuming bubbles.
- State, cnt and stall_cycles update on the rising clk edge only. There is no combinational path from cnt_clr to outputs other than through stall_cycles on the next edge.

## Test plan
- Setup: exmem_rd = 3 live and memwb_rd = 3 live, with ex_rs1 = 3 and ex_rs2 = 3. Expected: forward_a = forward_b = 10. With ex_rd = 0, ex_rs1 = 0 and ZERO_REG = 1, forward_a = 00.
- Setup: load to x5 in EX, id_rs2 = 5 with id_use_rs2 = 1, LOAD_STALL = 1. Expected: one cycle of stall_if = stall_id = flush_idex = 1, then RUN; stall_cycles = 1.
- Setup: same hazard with LOAD_STALL = 3, and mem_busy = 1 in the second stall cycle. Expected: the stall window is 4 cycles with freeze = 1 in one of them; stall_cycles = 3.
- Setup: hit and ex_branch_taken in the same cycle. Expected: flush_ifid = flush_idex = 1, stall_if = 0, state remains RUN. Separately: rst asserted mid-LU_STALL, after which all outputs are 0 and state is RUN.
- Setup: memwb_rd = 7 live and id_rs1 = 7. Expected: id_bypass_a = 1. Separately, with CNT_W = 4, drive 20 stall cycles. Expected: stall_cycles = 15; cnt_clr gives 0 on the next edge.

Source files
------------

// File: rtl/hazard_forwarding_unit_if.sv
// Hazard/forwarding unit signal bundle: pipeline-side status in, stall/flush/select controls out.
// Combinational controls, same cycle; no handshake, mem_busy freezes the whole pipeline.
interface hazard_forwarding_unit_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [ADDR_W-1:0] id_rs1;
  logic [ADDR_W-1:0] id_rs2;
  logic [ADDR_W-1:0] ex_rs1;
  logic [ADDR_W-1:0] ex_rs2;
  logic [ADDR_W-1:0] ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              ex_branch_taken;
  logic [ADDR_W-1:0] exmem_rd;
  logic              exmem_regwrite;
  logic              exmem_memread;
  logic [ADDR_W-1:0] memwb_rd;
  logic              memwb_regwrite;
  logic              mem_busy;
  logic              cnt_clr;

  logic [1:0]        forward_a;
  logic [1:0]        forward_b;
  logic              id_bypass_a;
  logic              id_bypass_b;
  logic              stall_if;
  logic              stall_id;
  logic              flush_ifid;
  logic              flush_idex;
  logic              freeze;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output id_valid, id_use_rs1, id_use_rs2, id_rs1, id_rs2,
           ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread, ex_branch_taken,
           exmem_rd, exmem_regwrite, exmem_memread,
           memwb_rd, memwb_regwrite, mem_busy, cnt_clr,
    input  forward_a, forward_b, id_bypass_a, id_bypass_b,
           stall_if, stall_id, flush_ifid, flush_idex, freeze, stall_cycles
  );

  modport slave (
    input  id_valid, id_use_rs1, id_use_rs2, id_rs1, id_rs2,
           ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread, ex_branch_taken,
           exmem_rd, exmem_regwrite, exmem_memread,
           memwb_rd, memwb_regwrite, mem_busy, cnt_clr,
    output forward_a, forward_b, id_bypass_a, id_bypass_b,
           stall_if, stall_id, flush_ifid, flush_idex, freeze, stall_cycles
  );
endinterface

// File: rtl/hazard_forwarding_unit.sv
// Operand forwarding, decode bypass and load-use/branch/freeze hazard control for a 5-stage pipe.
// Controls are combinational (0 cycles); load-use inserts LOAD_STALL bubbles, mem_busy holds everything.
module hazard_forwarding_unit #(
  parameter int ADDR_W     = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16,
  parameter bit ZERO_REG   = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  hazard_forwarding_unit_if.slave bus
);

  localparam int              CW       = $clog2(LOAD_STALL) + 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(LOAD_STALL - 1);

  typedef enum logic {RUN, LU_STALL} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

  logic              exmem_live, memwb_live, ex_live, hit;
  logic [1:0]        forward_a, forward_b;
  logic              id_bypass_a, id_bypass_b;
  logic              stall_if, stall_id, flush_ifid, flush_idex, freeze;

  always_comb begin
    exmem_live = bus.exmem_regwrite && (!ZERO_REG || bus.exmem_rd != '0);
    memwb_live = bus.memwb_regwrite && (!ZERO_REG || bus.memwb_rd != '0);
    ex_live    = bus.ex_regwrite    && (!ZERO_REG || bus.ex_rd    != '0);
    hit        = bus.id_valid && bus.ex_memread && ex_live &&
                 ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
                  (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
  end

  always_comb begin
    forward_a      = 2'b00;
    forward_b      = 2'b00;
    id_bypass_a    = 1'b0;
    id_bypass_b    = 1'b0;
    stall_if       = 1'b0;
    stall_id       = 1'b0;
    flush_ifid     = 1'b0;
    flush_idex     = 1'b0;
    freeze         = 1'b0;
    state_d        = state_q;
    cnt_d          = cnt_q;
    stall_cycles_d = stall_cycles_q;

    if (!rst) begin
      // A load in EX/MEM has no data yet, so it may only be picked up from MEM/WB.
      if (exmem_live && !bus.exmem_memread && bus.exmem_rd == bus.ex_rs1)
        forward_a = 2'b10;
      else if (memwb_live && bus.memwb_rd == bus.ex_rs1)
        forward_a = 2'b01;

      if (exmem_live && !bus.exmem_memread && bus.exmem_rd == bus.ex_rs2)
        forward_b = 2'b10;
      else if (memwb_live && bus.memwb_rd == bus.ex_rs2)
        forward_b = 2'b01;

      id_bypass_a = memwb_live && bus.memwb_rd == bus.id_rs1 && bus.id_use_rs1;
      id_bypass_b = memwb_live && bus.memwb_rd == bus.id_rs2 && bus.id_use_rs2;
      freeze      = bus.mem_busy;

      // Under freeze the FSM holds, so a pending hit is simply re-seen afterwards.
      if (!bus.mem_busy) begin
        if (bus.ex_branch_taken) begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end
        if (state_q == LU_STALL) begin
          stall_if   = 1'b1;
          stall_id   = 1'b1;
          flush_idex = 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end else if (hit && !bus.ex_branch_taken) begin
          stall_if   = 1'b1;
          stall_id   = 1'b1;
          flush_idex = 1'b1;
          if (LOAD_STALL > 1) begin
            state_d = LU_STALL;
            cnt_d   = CNT_INIT;
          end
        end
      end
    end

    if (bus.cnt_clr)
      stall_cycles_d = '0;
    else if (stall_if && !freeze && stall_cycles_q != '1)
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.forward_a    = forward_a;
  assign bus.forward_b    = forward_b;
  assign bus.id_bypass_a  = id_bypass_a;
  assign bus.id_bypass_b  = id_bypass_b;
  assign bus.stall_if     = stall_if;
  assign bus.stall_id     = stall_id;
  assign bus.flush_ifid   = flush_ifid;
  assign bus.flush_idex   = flush_idex;
  assign bus.freeze       = freeze;
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Directed bench for two hazard_forwarding_unit instances (LOAD_STALL=3/CNT_W=4 and LOAD_STALL=1/CNT_W=16).
// Stimulus pushes expected outputs into a queue; a negedge monitor pops and compares.
module tb_hazard_forwarding_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       id_valid, id_use_rs1, id_use_rs2;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, exmem_rd, memwb_rd;
  logic       ex_regwrite, ex_memread, ex_branch_taken;
  logic       exmem_regwrite, exmem_memread, memwb_regwrite, mem_busy, cnt_clr;

  hazard_forwarding_unit_if #(.ADDR_W(5), .CNT_W(4))  bus_a ();
  hazard_forwarding_unit_if #(.ADDR_W(5), .CNT_W(16)) bus_b ();

  assign bus_a.id_valid = id_valid;               assign bus_b.id_valid = id_valid;
  assign bus_a.id_use_rs1 = id_use_rs1;           assign bus_b.id_use_rs1 = id_use_rs1;
  assign bus_a.id_use_rs2 = id_use_rs2;           assign bus_b.id_use_rs2 = id_use_rs2;
  assign bus_a.id_rs1 = id_rs1;                   assign bus_b.id_rs1 = id_rs1;
  assign bus_a.id_rs2 = id_rs2;                   assign bus_b.id_rs2 = id_rs2;
  assign bus_a.ex_rs1 = ex_rs1;                   assign bus_b.ex_rs1 = ex_rs1;
  assign bus_a.ex_rs2 = ex_rs2;                   assign bus_b.ex_rs2 = ex_rs2;
  assign bus_a.ex_rd = ex_rd;                     assign bus_b.ex_rd = ex_rd;
  assign bus_a.ex_regwrite = ex_regwrite;         assign bus_b.ex_regwrite = ex_regwrite;
  assign bus_a.ex_memread = ex_memread;           assign bus_b.ex_memread = ex_memread;
  assign bus_a.ex_branch_taken = ex_branch_taken; assign bus_b.ex_branch_taken = ex_branch_taken;
  assign bus_a.exmem_rd = exmem_rd;               assign bus_b.exmem_rd = exmem_rd;
  assign bus_a.exmem_regwrite = exmem_regwrite;   assign bus_b.exmem_regwrite = exmem_regwrite;
  assign bus_a.exmem_memread = exmem_memread;     assign bus_b.exmem_memread = exmem_memread;
  assign bus_a.memwb_rd = memwb_rd;               assign bus_b.memwb_rd = memwb_rd;
  assign bus_a.memwb_regwrite = memwb_regwrite;   assign bus_b.memwb_regwrite = memwb_regwrite;
  assign bus_a.mem_busy = mem_busy;               assign bus_b.mem_busy = mem_busy;
  assign bus_a.cnt_clr = cnt_clr;                 assign bus_b.cnt_clr = cnt_clr;

  hazard_forwarding_unit #(.ADDR_W(5), .LOAD_STALL(3), .CNT_W(4), .ZERO_REG(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );
  hazard_forwarding_unit #(.ADDR_W(5), .LOAD_STALL(1), .CNT_W(16), .ZERO_REG(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  // {fa[1:0], fb[1:0], byp_a, byp_b, stall_if, stall_id, flush_ifid, flush_idex, freeze, stall_cycles[15:0]}
  typedef struct {
    string       name;
    bit          dut;
    logic [26:0] vec;
  } exp_t;

  exp_t scq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   sc_a    = 0;
  int   sc_b    = 0;

  function automatic logic [26:0] obs(input bit dut);
    if (dut == 1'b0)
      return {bus_a.forward_a, bus_a.forward_b, bus_a.id_bypass_a, bus_a.id_bypass_b,
              bus_a.stall_if, bus_a.stall_id, bus_a.flush_ifid, bus_a.flush_idex,
              bus_a.freeze, 12'd0, bus_a.stall_cycles};
    return {bus_b.forward_a, bus_b.forward_b, bus_b.id_bypass_a, bus_b.id_bypass_b,
            bus_b.stall_if, bus_b.stall_id, bus_b.flush_ifid, bus_b.flush_idex,
            bus_b.freeze, bus_b.stall_cycles};
  endfunction

  always @(negedge clk) begin
    while (scq.size() > 0) begin
      exp_t e;
      logic [26:0] got;
      e   = scq.pop_front();
      got = obs(e.dut);
      n_tests++;
      if (got !== e.vec) begin
        n_fail++;
        $display("FAIL %s dut%0d: got fa=%b fb=%b byp=%b stl=%b fl=%b frz=%b sc=%0d, expected fa=%b fb=%b byp=%b stl=%b fl=%b frz=%b sc=%0d",
                 e.name, e.dut, got[26:25], got[24:23], got[22:21], got[20:19], got[18:17], got[16], got[15:0],
                 e.vec[26:25], e.vec[24:23], e.vec[22:21], e.vec[20:19], e.vec[18:17], e.vec[16], e.vec[15:0]);
      end
    end
  end

  task automatic idle();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0; ex_branch_taken = 0;
    exmem_rd = 0; exmem_regwrite = 0; exmem_memread = 0; memwb_rd = 0; memwb_regwrite = 0;
    mem_busy = 0; cnt_clr = 0;
  endtask

  // load to x5 in EX, decode reads x5 as rs2
  task automatic hazard();
    idle();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5;
    id_valid = 1; id_use_rs2 = 1; id_rs2 = 5;
  endtask

  // ca/cb = {stall_if&stall_id, flush_ifid, flush_idex} for dut a / dut b
  task automatic step(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                      input logic ba, input logic bb, input logic [2:0] ca,
                      input logic [2:0] cb, input logic frz);
    exp_t e;
    e.name = nm;
    e.dut  = 1'b0;
    e.vec  = {fa, fb, ba, bb, ca[2], ca[2], ca[1], ca[0], frz, 16'(sc_a)};
    scq.push_back(e);
    e.dut  = 1'b1;
    e.vec  = {fa, fb, ba, bb, cb[2], cb[2], cb[1], cb[0], frz, 16'(sc_b)};
    scq.push_back(e);
    @(posedge clk);
    if (rst || cnt_clr) begin
      sc_a = 0;
      sc_b = 0;
    end else begin
      if (ca[2] && !frz && sc_a != 15)    sc_a++;
      if (cb[2] && !frz && sc_b != 65535) sc_b++;
    end
    #1;
  endtask

  initial begin
    rst = 1;
    idle();
    repeat (2) @(posedge clk);
    #1;

    hazard(); ex_branch_taken = 1; mem_busy = 1; exmem_rd = 3; exmem_regwrite = 1; ex_rs1 = 3;
    step("reset_outputs", 2'b00, 2'b00, 0, 0, 3'b000, 3'b000, 0);
    rst = 0;

    idle(); exmem_rd = 3; exmem_regwrite = 1; memwb_rd = 3; memwb_regwrite = 1; ex_rs1 = 3; ex_rs2 = 3;
    step("fwd_exmem_priority", 2'b10, 2'b10, 0, 0, 3'b000, 3'b000, 0);
    idle(); exmem_regwrite = 1; memwb_regwrite = 1; ex_regwrite = 1;
    step("fwd_zero_reg", 2'b00, 2'b00, 0, 0, 3'b000, 3'b000, 0);
    idle(); exmem_rd = 4; exmem_regwrite = 1; exmem_memread = 1; memwb_rd = 4; memwb_regwrite = 1; ex_rs1 = 4; ex_rs2 = 6;
    step("fwd_load_in_exmem", 2'b01, 2'b00, 0, 0, 3'b000, 3'b000, 0);
    idle(); exmem_rd = 2; exmem_regwrite = 1; memwb_rd = 9; memwb_regwrite = 1; ex_rs1 = 9; ex_rs2 = 2;
    step("fwd_split", 2'b01, 2'b10, 0, 0, 3'b000, 3'b000, 0);
    idle(); exmem_rd = 2; memwb_rd = 2; ex_rs1 = 2; ex_rs2 = 2;
    step("fwd_no_regwrite", 2'b00, 2'b00, 0, 0, 3'b000, 3'b000, 0);
    idle(); memwb_rd = 7; memwb_regwrite = 1; id_rs1 = 7; id_use_rs1 = 1; id_rs2 = 7;
    step("bypass_a", 2'b00, 2'b00, 1, 0, 3'b000, 3'b000, 0);
    idle(); memwb_rd = 7; memwb_regwrite = 1; id_rs1 = 7; id_rs2 = 7; id_use_rs2 = 1;
    step("bypass_b", 2'b00, 2'b00, 0, 1, 3'b000, 3'b000, 0);
    idle(); memwb_regwrite = 1; id_use_rs1 = 1;
    step("bypass_zero_reg", 2'b00, 2'b00, 0, 0, 3'b000, 3'b000, 0);

    hazard();
    step("lu_hit", 2'b00, 2'b00, 0, 0, 3'b101, 3'b101, 0);
    idle(); mem_busy = 1;
    step("lu_freeze", 2'b00, 2'b00, 0, 0, 3'b000, 3'b000, 1);
    idle();
    step("lu_bubble2", 2'b00, 2'b00, 0, 0, 3'b101, 3'b000, 0);
    step("lu_bubble3", 2'b00, 2'b00, 0, 0, 3'b101, 3'b000, 0);
    step("lu_done", 2'b00, 2'b00, 0, 0, 3'b000, 3'b000, 0);

    hazard(); id_use_rs2 = 0;
    step("no_hit_unused", 2'b00, 2'b00, 0, 0, 3'b000, 3'b000, 0);
    hazard(); id_valid = 0;
    step("no_hit_invalid", 2'b00, 2'b00, 0, 0, 3'b000, 3'b000, 0);
    hazard(); ex_rd = 0; id_rs2 = 0;
    step("no_hit_zero_reg", 2'b00, 2'b00, 0, 0, 3'b000, 3'b000, 0);

    hazard(); ex_branch_taken = 1;
    step("branch_wins", 2'b00, 2'b00, 0, 0, 3'b011, 3'b011, 0);
    idle();
    step("branch_stays_run", 2'b00, 2'b00, 0, 0, 3'b000, 3'b000, 0);

    hazard(); mem_busy = 1;
    step("hit_under_freeze", 2'b00, 2'b00, 0, 0, 3'b000, 3'b000, 1);
    hazard();
    step("hit_after_freeze", 2'b00, 2'b00, 0, 0, 3'b101, 3'b101, 0);
    idle(); rst = 1;
    step("reset_mid_stall", 2'b00, 2'b00, 0, 0, 3'b000, 3'b000, 0);
    rst = 0;
    step("after_reset_run", 2'b00, 2'b00, 0, 0, 3'b000, 3'b000, 0);

    hazard();
    for (int i = 0; i < 21; i++)
      step("sat_stall", 2'b00, 2'b00, 0, 0, 3'b101, 3'b101, 0);
    idle();
    step("sat_hold", 2'b00, 2'b00, 0, 0, 3'b000, 3'b000, 0);
    cnt_clr = 1;
    step("clr_not_comb", 2'b00, 2'b00, 0, 0, 3'b000, 3'b000, 0);
    cnt_clr = 0;
    step("clr_done", 2'b00, 2'b00, 0, 0, 3'b000, 3'b000, 0);

    for (int i = 0; i < 10 && scq.size() > 0; i++) @(negedge clk);
    if (scq.size() > 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", scq.size());
    end
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
